// File: rtl/time_keeper.sv
// time_keeper: timekeeping core of the digital clock.
// Counts seconds from a prescaled tick, wraps at 23:59:59, accepts range-checked
// set-value loads and presents binary plus registered BCD time fields.
module time_keeper #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  H_IN,
    input  logic [5:0]  M_IN,
    input  logic [5:0]  S_IN,
    input  logic        set_mode,
    input  logic        load,
    output logic [4:0]  HOURS,
    output logic [5:0]  MINS,
    output logic [5:0]  SECS,
    output logic [23:0] BCD,
    output logic        sec_pulse,
    output logic        day_roll,
    output logic        load_err
);

    localparam int unsigned    PW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRE_MAX = PW'(TICK_DIV - 1);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]    state;
    logic [PW-1:0] pre;
    logic          load_ok;
    logic          tick;
    logic          s_wrap;
    logic          m_wrap;
    logic          h_wrap;

    // Binary (0..63) to two BCD digits by repeated subtraction of ten.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [5:0] rem;
        tens = '0;
        rem  = v;
        for (int unsigned i = 0; i < 6; i++) begin
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, 4'(rem)};
    endfunction

    // Load validation, second tick and field wrap detection.
    always_comb begin
        load_ok = load && (H_IN <= 5'd23) && (M_IN <= 6'd59) && (S_IN <= 6'd59);
        tick    = (state == RUN) && (pre == PRE_MAX);
        s_wrap  = (SECS == 6'd59);
        m_wrap  = (MINS == 6'd59);
        h_wrap  = (HOURS == 5'd23);
    end

    // RUN/HOLD mode follows the set_mode level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= RUN;
        else        state <= set_mode ? HOLD : RUN;
    end

    // Prescaler: zeroed by a valid load or in HOLD, otherwise counts and wraps on tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                pre <= '0;
        else if (load_ok)          pre <= '0;
        else if (state == HOLD)    pre <= '0;
        else if (pre == PRE_MAX)   pre <= '0;
        else                       pre <= pre + 1'b1;
    end

    // Time fields and event pulses; a valid load replaces a coincident tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            HOURS     <= '0;
            MINS      <= '0;
            SECS      <= '0;
            sec_pulse <= 1'b0;
            day_roll  <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            sec_pulse <= 1'b0;
            day_roll  <= 1'b0;
            load_err  <= load && !load_ok;
            if (load_ok) begin
                HOURS <= H_IN;
                MINS  <= M_IN;
                SECS  <= S_IN;
            end else if (tick) begin
                sec_pulse <= 1'b1;
                if (s_wrap) begin
                    SECS <= '0;
                    if (m_wrap) begin
                        MINS <= '0;
                        if (h_wrap) begin
                            HOURS    <= '0;
                            day_roll <= 1'b1;
                        end else begin
                            HOURS <= HOURS + 5'd1;
                        end
                    end else begin
                        MINS <= MINS + 6'd1;
                    end
                end else begin
                    SECS <= SECS + 6'd1;
                end
            end
        end
    end

    // BCD image of the registered fields, one cycle behind them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) BCD <= '0;
        else        BCD <= {to_bcd({1'b0, HOURS}), to_bcd(MINS), to_bcd(SECS)};
    end

endmodule

// File: tb/tb_time_keeper.sv
// Self-checking bench for time_keeper with TICK_DIV = 4.
// A behavioural clock model pushes expected outputs per cycle; each scenario
// task pops and compares them, plus explicit constant checks from the plan.
module tb_time_keeper;

    logic        clk;
    logic        reset;
    logic [4:0]  H_IN;
    logic [5:0]  M_IN;
    logic [5:0]  S_IN;
    logic        set_mode;
    logic        load;
    logic [4:0]  HOURS;
    logic [5:0]  MINS;
    logic [5:0]  SECS;
    logic [23:0] BCD;
    logic        sec_pulse;
    logic        day_roll;
    logic        load_err;

    typedef struct {
        logic [4:0]  h;
        logic [5:0]  m;
        logic [5:0]  s;
        logic        pulse;
        logic        roll;
        logic        err;
        logic [23:0] bcd;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Model state
    int   m_h, m_m, m_s, m_pre;
    bit   m_run;
    logic [23:0] m_bcd;

    time_keeper #(.TICK_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .H_IN      (H_IN),
        .M_IN      (M_IN),
        .S_IN      (S_IN),
        .set_mode  (set_mode),
        .load      (load),
        .HOURS     (HOURS),
        .MINS      (MINS),
        .SECS      (SECS),
        .BCD       (BCD),
        .sec_pulse (sec_pulse),
        .day_roll  (day_roll),
        .load_err  (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, need finished");
        $fatal(1);
    end

    function automatic logic [7:0] bcd2(input int v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    task automatic reset_model();
        m_h = 0; m_m = 0; m_s = 0; m_pre = 0; m_run = 1'b1; m_bcd = '0;
        sb.delete();
    endtask

    // Drive one cycle of inputs, advance the model, push its expectation.
    task automatic step(input logic ld, input logic [4:0] h, input logic [5:0] mi,
                        input logic [5:0] s, input logic sm);
        exp_t e;
        bit   valid;
        bit   tick_now;
        load = ld; H_IN = h; M_IN = mi; S_IN = s; set_mode = sm;
        valid    = ld && (h <= 23) && (mi <= 59) && (s <= 59);
        tick_now = m_run && (m_pre == 3);
        e.bcd    = {bcd2(m_h), bcd2(m_m), bcd2(m_s)};
        e.pulse  = 1'b0;
        e.roll   = 1'b0;
        e.err    = ld && !valid;
        if (valid) begin
            m_h = int'(h); m_m = int'(mi); m_s = int'(s); m_pre = 0;
        end else begin
            if (!m_run)          m_pre = 0;
            else if (m_pre == 3) m_pre = 0;
            else                 m_pre = m_pre + 1;
            if (tick_now) begin
                e.pulse = 1'b1;
                m_s = m_s + 1;
                if (m_s == 60) begin
                    m_s = 0; m_m = m_m + 1;
                    if (m_m == 60) begin
                        m_m = 0; m_h = m_h + 1;
                        if (m_h == 24) begin
                            m_h = 0; e.roll = 1'b1;
                        end
                    end
                end
            end
        end
        m_run = !sm;
        e.h = 5'(m_h); e.m = 6'(m_m); e.s = 6'(m_s);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 6'd0, 6'd0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0; load = 1'b0; set_mode = 1'b0;
        H_IN = '0; M_IN = '0; S_IN = '0;
        reset_model();
        #1;
        vectors++;
        if ({HOURS, MINS, SECS, BCD, sec_pulse, day_roll, load_err} !== 44'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %h %h %h %h %b%b%b, need all zero",
                     HOURS, MINS, SECS, BCD, sec_pulse, day_roll, load_err);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_count();
        exp_t e;
        for (int k = 1; k <= 12; k++) begin
            idle();
            e = sb.pop_front();
            vectors++;
            if ({HOURS, MINS, SECS, sec_pulse, day_roll, load_err, BCD} !==
                {e.h, e.m, e.s, e.pulse, e.roll, e.err, e.bcd}) begin
                miscompares++;
                $display("FAIL count_model cyc %0d: got %0d:%0d:%0d p%b r%b e%b bcd %h, need %0d:%0d:%0d p%b r%b e%b bcd %h",
                         k, HOURS, MINS, SECS, sec_pulse, day_roll, load_err, BCD,
                         e.h, e.m, e.s, e.pulse, e.roll, e.err, e.bcd);
            end
            vectors++;
            if (sec_pulse !== (k % 4 == 0) || SECS !== 6'(k / 4) || BCD[3:0] !== 4'((k - 1) / 4)) begin
                miscompares++;
                $display("FAIL count_plan cyc %0d: got pulse %b secs %0d s1 %0d, need pulse %b secs %0d s1 %0d",
                         k, sec_pulse, SECS, BCD[3:0], (k % 4 == 0), k / 4, (k - 1) / 4);
            end
        end
    endtask

    task automatic test_load_run();
        exp_t e;
        int   pulses = 0;
        step(1'b1, 5'd12, 6'd34, 6'd56, 1'b0);
        e = sb.pop_front();
        vectors++;
        if ({HOURS, MINS, SECS} !== {e.h, e.m, e.s} || {HOURS, MINS, SECS} !== {5'd12, 6'd34, 6'd56}) begin
            miscompares++;
            $display("FAIL load_capture: got %0d:%0d:%0d, need 12:34:56", HOURS, MINS, SECS);
        end
        for (int k = 1; k <= 17; k++) begin
            idle();
            e = sb.pop_front();
            pulses += int'(sec_pulse);
            vectors++;
            if ({HOURS, MINS, SECS, sec_pulse, day_roll, load_err, BCD} !==
                {e.h, e.m, e.s, e.pulse, e.roll, e.err, e.bcd}) begin
                miscompares++;
                $display("FAIL load_run_model cyc %0d: got %0d:%0d:%0d p%b bcd %h, need %0d:%0d:%0d p%b bcd %h",
                         k, HOURS, MINS, SECS, sec_pulse, BCD, e.h, e.m, e.s, e.pulse, e.bcd);
            end
        end
        vectors++;
        if (pulses != 4 || {HOURS, MINS, SECS} !== {5'd12, 6'd35, 6'd0} || BCD !== 24'h123500) begin
            miscompares++;
            $display("FAIL load_run_final: got %0d pulses %0d:%0d:%0d bcd %h, need 4 pulses 12:35:0 bcd 123500",
                     pulses, HOURS, MINS, SECS, BCD);
        end
    endtask

    task automatic test_day_roll();
        exp_t e;
        int   rolls = 0;
        step(1'b1, 5'd23, 6'd59, 6'd59, 1'b0);
        void'(sb.pop_front());
        for (int k = 1; k <= 5; k++) begin
            idle();
            e = sb.pop_front();
            rolls += int'(day_roll);
            vectors++;
            if ({HOURS, MINS, SECS, sec_pulse, day_roll, BCD} !== {e.h, e.m, e.s, e.pulse, e.roll, e.bcd}) begin
                miscompares++;
                $display("FAIL day_roll_model cyc %0d: got %0d:%0d:%0d p%b r%b bcd %h, need %0d:%0d:%0d p%b r%b bcd %h",
                         k, HOURS, MINS, SECS, sec_pulse, day_roll, BCD, e.h, e.m, e.s, e.pulse, e.roll, e.bcd);
            end
            if (k == 4) begin
                vectors++;
                if ({HOURS, MINS, SECS} !== 17'd0 || sec_pulse !== 1'b1 || day_roll !== 1'b1 || BCD !== 24'h235959) begin
                    miscompares++;
                    $display("FAIL day_roll_wrap: got %0d:%0d:%0d p%b r%b bcd %h, need 0:0:0 p1 r1 bcd 235959",
                             HOURS, MINS, SECS, sec_pulse, day_roll, BCD);
                end
            end
        end
        vectors++;
        if (rolls != 1 || BCD !== 24'h000000) begin
            miscompares++;
            $display("FAIL day_roll_count: got %0d rolls bcd %h, need 1 roll bcd 000000", rolls, BCD);
        end
    endtask

    task automatic test_bad_load();
        exp_t e;
        step(1'b1, 5'd10, 6'd20, 6'd30, 1'b0);
        void'(sb.pop_front());
        idle(); void'(sb.pop_front());
        idle(); void'(sb.pop_front());
        step(1'b1, 5'd24, 6'd0, 6'd0, 1'b0);
        e = sb.pop_front();
        vectors++;
        if (load_err !== 1'b1 || {HOURS, MINS, SECS} !== {5'd10, 6'd20, 6'd30} || load_err !== e.err) begin
            miscompares++;
            $display("FAIL bad_hour: got err %b %0d:%0d:%0d, need err 1 10:20:30", load_err, HOURS, MINS, SECS);
        end
        idle();
        e = sb.pop_front();
        vectors++;
        if (sec_pulse !== 1'b1 || SECS !== 6'd31 || load_err !== 1'b0 || SECS !== e.s) begin
            miscompares++;
            $display("FAIL bad_hour_phase: got pulse %b secs %0d err %b, need pulse 1 secs 31 err 0",
                     sec_pulse, SECS, load_err);
        end
        for (int k = 0; k < 3; k++) begin
            idle(); void'(sb.pop_front());
        end
        step(1'b1, 5'd5, 6'd60, 6'd0, 1'b0);
        e = sb.pop_front();
        vectors++;
        if (load_err !== 1'b1 || sec_pulse !== 1'b1 || {HOURS, MINS, SECS} !== {5'd10, 6'd20, 6'd32} ||
            {HOURS, MINS, SECS, sec_pulse, load_err} !== {e.h, e.m, e.s, e.pulse, e.err}) begin
            miscompares++;
            $display("FAIL bad_min_with_tick: got err %b pulse %b %0d:%0d:%0d, need err 1 pulse 1 10:20:32",
                     load_err, sec_pulse, HOURS, MINS, SECS);
        end
        idle();
        e = sb.pop_front();
        vectors++;
        if (load_err !== 1'b0 || load_err !== e.err) begin
            miscompares++;
            $display("FAIL load_err_width: got %b, need 0", load_err);
        end
    endtask

    task automatic test_hold();
        exp_t e;
        int   pulses = 0;
        int   frozen_bad = 0;
        step(1'b1, 5'd1, 6'd2, 6'd3, 1'b0);
        void'(sb.pop_front());
        idle(); void'(sb.pop_front());
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 5'd0, 6'd0, 6'd0, 1'b1);
            void'(sb.pop_front());
            pulses += int'(sec_pulse);
            if ({HOURS, MINS, SECS} !== {5'd1, 6'd2, 6'd3}) frozen_bad++;
        end
        vectors++;
        if (pulses != 0 || frozen_bad != 0) begin
            miscompares++;
            $display("FAIL hold_frozen: got %0d pulses %0d changed cycles, need 0 and 0", pulses, frozen_bad);
        end
        idle(); void'(sb.pop_front());
        for (int k = 1; k <= 4; k++) begin
            idle();
            e = sb.pop_front();
            vectors++;
            if (sec_pulse !== (k == 4) || sec_pulse !== e.pulse || SECS !== e.s) begin
                miscompares++;
                $display("FAIL hold_release cyc %0d: got pulse %b secs %0d, need pulse %b secs %0d",
                         k, sec_pulse, SECS, (k == 4), e.s);
            end
        end
        vectors++;
        if (SECS !== 6'd4) begin
            miscompares++;
            $display("FAIL hold_resume_value: got %0d, need 4", SECS);
        end
    endtask

    task automatic test_load_tick();
        exp_t e;
        step(1'b1, 5'd5, 6'd6, 6'd7, 1'b0);
        void'(sb.pop_front());
        for (int k = 0; k < 3; k++) begin
            idle(); void'(sb.pop_front());
        end
        step(1'b1, 5'd8, 6'd9, 6'd10, 1'b0);
        e = sb.pop_front();
        vectors++;
        if (sec_pulse !== 1'b0 || {HOURS, MINS, SECS} !== {5'd8, 6'd9, 6'd10} ||
            {HOURS, MINS, SECS, sec_pulse} !== {e.h, e.m, e.s, e.pulse}) begin
            miscompares++;
            $display("FAIL load_over_tick: got pulse %b %0d:%0d:%0d, need pulse 0 8:9:10",
                     sec_pulse, HOURS, MINS, SECS);
        end
        for (int k = 1; k <= 4; k++) begin
            idle();
            e = sb.pop_front();
            vectors++;
            if (sec_pulse !== (k == 4) || SECS !== e.s || BCD !== e.bcd) begin
                miscompares++;
                $display("FAIL load_tick_next cyc %0d: got pulse %b secs %0d bcd %h, need pulse %b secs %0d bcd %h",
                         k, sec_pulse, SECS, BCD, (k == 4), e.s, e.bcd);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, 5'(k), 6'(k), 6'(k), 1'b0);
            e = sb.pop_front();
            vectors++;
            if ({HOURS, MINS, SECS} !== {5'(k), 6'(k), 6'(k)} || sec_pulse !== 1'b0 || BCD !== e.bcd) begin
                miscompares++;
                $display("FAIL b2b_load %0d: got %0d:%0d:%0d pulse %b bcd %h, need %0d:%0d:%0d pulse 0 bcd %h",
                         k, HOURS, MINS, SECS, sec_pulse, BCD, k, k, k, e.bcd);
            end
        end
        for (int k = 1; k <= 4; k++) begin
            idle();
            e = sb.pop_front();
            vectors++;
            if (sec_pulse !== (k == 4) || SECS !== e.s) begin
                miscompares++;
                $display("FAIL b2b_phase cyc %0d: got pulse %b secs %0d, need pulse %b secs %0d",
                         k, sec_pulse, SECS, (k == 4), e.s);
            end
        end
    endtask

    task automatic test_reset_mid();
        idle(); void'(sb.pop_front());
        idle(); void'(sb.pop_front());
        #3;
        reset = 1'b0;
        #1;
        vectors++;
        if ({HOURS, MINS, SECS, BCD, sec_pulse, day_roll, load_err} !== 44'd0) begin
            miscompares++;
            $display("FAIL reset_async: got %h %h %h %h %b%b%b, need all zero",
                     HOURS, MINS, SECS, BCD, sec_pulse, day_roll, load_err);
        end
        reset_model();
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            idle();
            void'(sb.pop_front());
            vectors++;
            if (sec_pulse !== (k == 4) || SECS !== 6'(k / 4) || HOURS !== 5'd0) begin
                miscompares++;
                $display("FAIL reset_restart cyc %0d: got pulse %b secs %0d hours %0d, need pulse %b secs %0d hours 0",
                         k, sec_pulse, SECS, HOURS, (k == 4), k / 4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_load_run();
        test_day_roll();
        test_bad_load();
        test_hold();
        test_load_tick();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
